// File: rtl/periodic_irq_gen.sv
// Multi-channel periodic interrupt generator: per-channel period, enable, pulse/level mode,
// level acknowledge and sticky overrun. Define PERIODIC_IRQ_GEN_CYCLE_CNT_EN for the cycle counter.
module periodic_irq_gen #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    PoR_rst,
  input  logic                    run_i,
  input  logic [NUM_CH-1:0]       en_i,
  input  logic [NUM_CH-1:0]       mode_i,
  input  logic [NUM_CH*CNT_W-1:0] period_i,
  input  logic [NUM_CH-1:0]       ack_i,
  input  logic [NUM_CH-1:0]       ovr_clr_i,
  output logic [NUM_CH-1:0]       irq_o,
  output logic [NUM_CH-1:0]       ovr_o,
  output logic [31:0]             cycle_cnt_o
);

  genvar k;
  generate
    for (k = 0; k < NUM_CH; k++) begin : g_ch
      logic [CNT_W-1:0] period;
      logic [CNT_W-1:0] period_m1;
      logic [CNT_W-1:0] cnt;
      logic             act;
      logic             tick;
      logic             irq_q;
      logic             ovr_q;

      assign period    = period_i[k*CNT_W +: CNT_W];
      assign period_m1 = period - CNT_W'(1);
      assign act       = run_i & en_i[k] & (period != '0);
      // >= lets a shrunk period fire right away instead of wrapping around
      assign tick      = act & (cnt >= period_m1);

      always_ff @(posedge clk or posedge PoR_rst) begin
        if (PoR_rst) begin
          cnt <= '0;
        end else if (!act || tick) begin
          cnt <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end

      always_ff @(posedge clk or posedge PoR_rst) begin
        if (PoR_rst) begin
          irq_q <= 1'b0;
        end else if (!mode_i[k]) begin
          irq_q <= tick;
        end else if (!act) begin
          irq_q <= 1'b0;
        end else if (tick) begin
          irq_q <= 1'b1;
        end else if (ack_i[k]) begin
          irq_q <= 1'b0;
        end
      end

      // Overrun only exists in level mode; a set beats a simultaneous clear
      always_ff @(posedge clk or posedge PoR_rst) begin
        if (PoR_rst) begin
          ovr_q <= 1'b0;
        end else if (mode_i[k]) begin
          if (tick && irq_q && !ack_i[k]) begin
            ovr_q <= 1'b1;
          end else if (ovr_clr_i[k]) begin
            ovr_q <= 1'b0;
          end
        end
      end

      assign irq_o[k] = irq_q;
      assign ovr_o[k] = ovr_q;
    end
  endgenerate

`ifdef PERIODIC_IRQ_GEN_CYCLE_CNT_EN
  logic [31:0] cycle_cnt_q;

  always_ff @(posedge clk or posedge PoR_rst) begin
    if (PoR_rst) begin
      cycle_cnt_q <= '0;
    end else if (run_i) begin
      cycle_cnt_q <= cycle_cnt_q + 32'd1;
    end else begin
      cycle_cnt_q <= '0;
    end
  end

  assign cycle_cnt_o = cycle_cnt_q;
`else
  assign cycle_cnt_o = '0;
`endif

endmodule

// File: tb/tb_periodic_irq_gen.sv
// Self-checking bench for periodic_irq_gen: directed scenarios plus randomized traffic,
// all compared against a cycle-level behavioural model of the channel rules.
module tb_periodic_irq_gen;
  localparam int NUM_CH = 4;
  localparam int CNT_W  = 16;

  logic                    clk = 1'b0;
  logic                    PoR_rst;
  logic                    run_i;
  logic [NUM_CH-1:0]       en_i, mode_i, ack_i, ovr_clr_i;
  logic [NUM_CH*CNT_W-1:0] period_i;
  logic [NUM_CH-1:0]       irq_o, ovr_o;
  logic [31:0]             cycle_cnt_o;

  int checks = 0;
  int errors = 0;

  periodic_irq_gen #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .clk(clk), .PoR_rst(PoR_rst), .run_i(run_i), .en_i(en_i), .mode_i(mode_i),
    .period_i(period_i), .ack_i(ack_i), .ovr_clr_i(ovr_clr_i),
    .irq_o(irq_o), .ovr_o(ovr_o), .cycle_cnt_o(cycle_cnt_o)
  );

  always #5 clk = ~clk;

  // Reference model: elapsed cycles since the channel became active or last ticked
  int unsigned       m_elapsed [NUM_CH];
  logic [NUM_CH-1:0] m_irq, m_ovr;
  logic [31:0]       m_cyc;

  function automatic int unsigned perOf(int k);
    return int'(period_i[k*CNT_W +: CNT_W]);
  endfunction

  function automatic bit isActive(int k);
    return run_i && en_i[k] && (perOf(k) != 0);
  endfunction

  function automatic bit isTick(int k);
    return isActive(k) && (m_elapsed[k] + 1 >= perOf(k));
  endfunction

  always @(posedge clk or posedge PoR_rst) begin
    if (PoR_rst) begin
      for (int k = 0; k < NUM_CH; k++) m_elapsed[k] <= 0;
      m_irq <= '0;
      m_ovr <= '0;
      m_cyc <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        m_elapsed[k] <= (!isActive(k) || isTick(k)) ? 0 : m_elapsed[k] + 1;
        if (!mode_i[k])           m_irq[k] <= isTick(k);
        else if (!isActive(k))    m_irq[k] <= 1'b0;
        else if (isTick(k))       m_irq[k] <= 1'b1;
        else if (ack_i[k])        m_irq[k] <= 1'b0;
        if (mode_i[k] && isTick(k) && m_irq[k] && !ack_i[k]) m_ovr[k] <= 1'b1;
        else if (mode_i[k] && ovr_clr_i[k])                   m_ovr[k] <= 1'b0;
      end
`ifdef PERIODIC_IRQ_GEN_CYCLE_CNT_EN
      m_cyc <= run_i ? m_cyc + 32'd1 : 32'd0;
`else
      m_cyc <= '0;
`endif
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic setPeriod(input int k, input int p);
    period_i[k*CNT_W +: CNT_W] = CNT_W'(p);
  endtask

  // Drive one cycle of inputs at a falling edge, then compare all outputs at the next falling edge
  task automatic applyStimulus(input logic r, input logic [NUM_CH-1:0] en, input logic [NUM_CH-1:0] mode,
                               input logic [NUM_CH-1:0] ack, input logic [NUM_CH-1:0] clr);
    run_i = r; en_i = en; mode_i = mode; ack_i = ack; ovr_clr_i = clr;
    @(negedge clk);
    checkOutput("irq_model", 32'(irq_o), 32'(m_irq));
    checkOutput("ovr_model", 32'(ovr_o), 32'(m_ovr));
    checkOutput("cyc_model", cycle_cnt_o, m_cyc);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cnt;
    logic [NUM_CH-1:0] en_r, mode_r;

    PoR_rst = 1'b1; run_i = 1'b0; en_i = '0; mode_i = '0; ack_i = '0; ovr_clr_i = '0; period_i = '0;
    #12;
    checkOutput("reset_irq", 32'(irq_o), 32'd0);
    checkOutput("reset_ovr", 32'(ovr_o), 32'd0);
    checkOutput("reset_cyc", cycle_cnt_o, 32'd0);
    @(negedge clk);
    PoR_rst = 1'b0;

    // Pulse mode, period 8
    setPeriod(0, 8);
    cnt = 0;
    do begin applyStimulus(1'b1, 4'b0001, 4'b0000, '0, '0); cnt++; end while (!irq_o[0] && cnt < 20);
    checkOutput("pulse_first", cnt, 8);
    cnt = 0;
    do begin applyStimulus(1'b1, 4'b0001, 4'b0000, '0, '0); cnt++; end while (!irq_o[0] && cnt < 20);
    checkOutput("pulse_gap", cnt, 8);
    applyStimulus(1'b1, 4'b0001, 4'b0000, '0, '0);
    checkOutput("pulse_width", 32'(irq_o[0]), 32'd0);

    // Level mode, period 4, ack then overrun then clear
    applyStimulus(1'b0, 4'b0010, 4'b0010, '0, '0);
    setPeriod(1, 4);
    cnt = 0;
    do begin applyStimulus(1'b1, 4'b0010, 4'b0010, '0, '0); cnt++; end while (!irq_o[1] && cnt < 20);
    checkOutput("level_first", cnt, 4);
    applyStimulus(1'b1, 4'b0010, 4'b0010, '0, '0);
    checkOutput("level_hold", 32'(irq_o[1]), 32'd1);
    applyStimulus(1'b1, 4'b0010, 4'b0010, 4'b0010, '0);
    checkOutput("level_ack", 32'(irq_o[1]), 32'd0);
    cnt = 0;
    do begin applyStimulus(1'b1, 4'b0010, 4'b0010, '0, '0); cnt++; end while (!irq_o[1] && cnt < 20);
    checkOutput("level_next", cnt, 2);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 4'b0010, 4'b0010, '0, '0);
    checkOutput("level_ovr_set", 32'(ovr_o[1]), 32'd1);
    applyStimulus(1'b1, 4'b0010, 4'b0010, '0, 4'b0010);
    checkOutput("level_ovr_clr", 32'(ovr_o[1]), 32'd0);

    // Ack coincident with a tick, period 3
    applyStimulus(1'b0, 4'b0010, 4'b0010, '0, '0);
    setPeriod(1, 3);
    applyStimulus(1'b1, 4'b0010, 4'b0010, '0, '0);
    applyStimulus(1'b1, 4'b0010, 4'b0010, '0, '0);
    applyStimulus(1'b1, 4'b0010, 4'b0010, 4'b0010, '0);
    checkOutput("acktick_irq", 32'(irq_o[1]), 32'd1);
    checkOutput("acktick_ovr", 32'(ovr_o[1]), 32'd0);

    // Period shrink 100 -> 10 at count 50, then period 0
    applyStimulus(1'b0, 4'b0100, 4'b0000, '0, '0);
    setPeriod(2, 100);
    for (int i = 0; i < 50; i++) applyStimulus(1'b1, 4'b0100, 4'b0000, '0, '0);
    setPeriod(2, 10);
    applyStimulus(1'b1, 4'b0100, 4'b0000, '0, '0);
    checkOutput("shrink_tick", 32'(irq_o[2]), 32'd1);
    setPeriod(2, 0);
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 4'b0100, 4'b0100, '0, '0);
    checkOutput("period0_irq", 32'(irq_o[2]), 32'd0);

    // Asynchronous reset with a level IRQ pending
    setPeriod(1, 2);
    cnt = 0;
    do begin applyStimulus(1'b1, 4'b0010, 4'b0010, '0, '0); cnt++; end while (!irq_o[1] && cnt < 20);
    checkOutput("pend_before_rst", 32'(irq_o[1]), 32'd1);
    #2 PoR_rst = 1'b1;
    #1;
    checkOutput("midrst_irq", 32'(irq_o), 32'd0);
    checkOutput("midrst_ovr", 32'(ovr_o), 32'd0);
    checkOutput("midrst_cyc", cycle_cnt_o, 32'd0);
    @(negedge clk);
    PoR_rst = 1'b0;

    // Randomized traffic
    en_r = '1; mode_r = '0;
    for (int i = 0; i < 600; i++) begin
      if (i % 16 == 0) begin
        for (int k = 0; k < NUM_CH; k++) setPeriod(k, int'($urandom_range(0, 7)));
        en_r = NUM_CH'($urandom) | NUM_CH'($urandom);
        mode_r = NUM_CH'($urandom);
      end
      begin
        logic [NUM_CH-1:0] ack_r, clr_r;
        ack_r = NUM_CH'($urandom) & NUM_CH'($urandom);
        clr_r = NUM_CH'($urandom) & NUM_CH'($urandom) & mode_r;
        applyStimulus(($urandom_range(0, 31) != 0), en_r, mode_r, ack_r, clr_r);
      end
    end

    // Cycle counter over 1000 edges
    applyStimulus(1'b0, '0, '0, '0, '0);
    for (int i = 0; i < 1000; i++) applyStimulus(1'b1, '0, '0, '0, '0);
`ifdef PERIODIC_IRQ_GEN_CYCLE_CNT_EN
    checkOutput("cyc_1000", cycle_cnt_o, 32'd1000);
    force dut.cycle_cnt_q = 32'hFFFF_FFFE;
    m_cyc = 32'hFFFF_FFFE;
    #1 release dut.cycle_cnt_q;
    applyStimulus(1'b1, '0, '0, '0, '0);
    checkOutput("cyc_max", cycle_cnt_o, 32'hFFFF_FFFF);
    applyStimulus(1'b1, '0, '0, '0, '0);
    checkOutput("cyc_wrap", cycle_cnt_o, 32'd0);
`else
    checkOutput("cyc_off", cycle_cnt_o, 32'd0);
`endif
    applyStimulus(1'b0, '0, '0, '0, '0);
    checkOutput("cyc_runlow", cycle_cnt_o, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/periodic_irq_gen.md
# periodic_irq_gen

Parametrised multi-channel periodic interrupt generator for the PicoRV32 × PULP SoC. It replaces the fixed two-line counter-bit IRQ stimulus with NUM_CH independently programmable channels. Each channel has a period, an enable and a pulse/level mode, and level-mode channels support acknowledge and a sticky overrun flag. Outputs feed the core's `irq` vector; the integrating top maps each channel to an IRQ bit.

## Interface
- `NUM_CH`, default 4: number of interrupt channels, 1..32.
- `CNT_W`, default 16: width of each period register and channel counter, 2..32.
- `clk` in 1: single clock, all state on rising edge.
- `PoR_rst` in 1: reset, asynchronous, active-high.
- `run_i` in 1: global count enable (tie to the CPU reset-release); low clears all counters.
- `en_i` in NUM_CH: per-channel enable.
- `mode_i` in NUM_CH: per-channel mode, 0 = pulse, 1 = level.
- `period_i` in NUM_CH*CNT_W: channel k period in bits [k*CNT_W +: CNT_W]; 0 = channel never ticks.
- `ack_i` in NUM_CH: level-mode acknowledge, clears the pending IRQ.
- `ovr_clr_i` in NUM_CH: clears the sticky overrun flag.
- `irq_o` out NUM_CH: interrupt outputs, registered.
- `ovr_o` out NUM_CH: sticky overrun flags, registered.
- `cycle_cnt_o` out 32: free-running cycle count (see Configuration).

## Operation
- Active condition for channel k: `act_k = run_i & en_i[k] & (period_k != 0)`.
- Counter `cnt_k` (CNT_W bits, unsigned):
  - If not `act_k`: `cnt_k <= 0`.
  - Else if `cnt_k >= period_k - 1`: this is a tick; `cnt_k <= 0`.
  - Else: `cnt_k <= cnt_k + 1`.
- The `>=` compare makes a shrinking period take effect without running to wrap-around. A growing period extends the current interval. `period_k - 1` is computed in CNT_W bits and is only evaluated when period ≠ 0.
- Pulse mode: `irq_o[k] <= tick_k`. The output is high for exactly one cycle per tick. `ack_i` and `ovr_o` have no effect; `ovr_o[k]` holds its value.
- Level mode, evaluated in priority order:
  1. Not `act_k`: `irq_o[k] <= 0`.
  2. `tick_k`: `irq_o[k] <= 1`.
  3. `ack_i[k]`: `irq_o[k] <= 0`.
  4. Otherwise hold.
- Overrun: `ovr_o[k] <= 1` when `tick_k & irq_o[k] & ~ack_i[k]` in level mode. Otherwise, `ovr_clr_i[k]` clears it. A set in the same cycle as a clear wins.
- Switching mode while active keeps the counter running. On a level→pulse switch, irq follows the pulse rule from the next edge.

## Timing
- Reset values: `irq_o = 0`, `ovr_o = 0`, all `cnt_k = 0`, `cycle_cnt_o = 0`.
- Reset mid-operation clears everything immediately (asynchronously). There is no pending state after release.
- Latency: with `act_k` high from edge 0, ticks occur at edges P, 2P, 3P, … `irq_o` is high in the cycle following each tick edge.
- Period 1: a tick on every edge. Pulse-mode `irq_o` stays continuously high. Level-mode `irq_o` stays high, and `ovr_o` sets on the second tick unless acknowledged.
- Counter wrap: no overflow is possible, because `cnt_k` never exceeds `period_k - 1 ≤ 2^CNT_W - 2`.
- Deasserting `en_i[k]` or `run_i` clears the counter and level IRQ on the next edge. Re-enabling restarts a full period.
- ack and tick in the same cycle: IRQ stays set, no overrun.

## Configuration
- `PERIODIC_IRQ_GEN_CYCLE_CNT_EN` defined:
  - A 32-bit `cycle_cnt_o` increments on every edge while `run_i` is high.
  - It is cleared to 0 on the edge where `run_i` is low.
  - It wraps from 0xFFFFFFFF to 0.
- Undefined: `cycle_cnt_o` is tied to 0 and no counter flops are generated.

## Test plan
- Pulse period: channel 0 with pulse mode, period 8, run from reset release → `irq_o[0]` is a one-cycle pulse every 8 cycles, with the first pulse 8 cycles after the first counting edge.
- Level mode with ack and overrun: channel 1 with level mode, period 4.
  - Ack 2 cycles after assertion → clears, and the next IRQ arrives 4 cycles after the prior tick.
  - No ack → on the next tick `ovr_o[1]` = 1.
  - `ovr_clr_i` pulse → `ovr_o[1]` = 0.
- Same-cycle ack and tick: level, period 3, ack driven exactly on a tick edge → `irq_o` stays 1, `ovr_o` stays 0.
- Period change: period 100 → 10 while `cnt` = 50 → tick on the next edge. Period 0 → `irq_o` = 0 permanently and the counter holds at 0.
- Reset and run: assert `PoR_rst` while a level IRQ is pending → `irq_o`, `ovr_o` and `cnt` all read 0 immediately. Dropping `run_i` → all counters clear.
- Cycle counter, with the macro defined: `run_i` high for 1000 edges → `cycle_cnt_o` = 1000; preload near 0xFFFFFFFF via force → wraps to 0. With the macro undefined → reads 0.
